// File: rtl/count_event_pkg.sv
// rtl/count_event_pkg.sv - shared event encodings and widths for the count event monitor
package count_event_pkg;

    localparam int STAMP_W = 8;
    localparam int EVT_W   = 2 + STAMP_W;

    typedef enum logic [1:0] {
        EVT_NONE  = 2'b00,
        EVT_MATCH = 2'b01,
        EVT_WRAP  = 2'b10,
        EVT_BOTH  = 2'b11
    } evt_type_e;

    typedef struct packed {
        logic [1:0]         etype;
        logic [STAMP_W-1:0] stamp;
    } evt_s;

endpackage

// File: rtl/event_fifo.sv
// rtl/event_fifo.sv - power-of-two event queue; a push into a full queue lands only alongside a pop
module event_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int OCC_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [OCC_W-1:0] occ;
    logic             wr_en;
    logic             rd_en;

    assign full  = (occ == OCC_W'(DEPTH));
    assign empty = (occ == '0);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // When full, wr_ptr equals rd_ptr: the write replaces the head that is leaving.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/count_event_monitor.sv
// rtl/count_event_monitor.sv - detects wrap and match events on a down counter and queues them with a wrap stamp
module count_event_monitor
    import count_event_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       count_in,
    input  logic               cmp_en,
    input  logic [N-1:0]       cmp_value,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [1:0]         evt_type,
    output logic [STAMP_W-1:0] evt_stamp,
    output logic [STAMP_W-1:0] wrap_count,
    output logic               overflow
);

    logic [N-1:0]       prev_q;
    logic               prev_valid;
    logic               wrap;
    logic               match;
    logic               event_hit;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [STAMP_W-1:0] wrap_next;
    evt_s               push_ev;
    evt_s               head_ev;

    always_comb begin
        wrap      = prev_valid && (prev_q == '0) && (count_in == {N{1'b1}});
        match     = prev_valid && cmp_en && (count_in == cmp_value) && (count_in != prev_q);
        event_hit = wrap || match;
        wrap_next = wrap_count + 1'b1;
        push_ev.etype = {wrap, match};
        push_ev.stamp = wrap ? wrap_next : wrap_count;
    end

    assign evt_valid = !fifo_empty;
    assign pop       = evt_valid && evt_ready;
    assign evt_type  = evt_valid ? head_ev.etype : EVT_NONE;
    assign evt_stamp = evt_valid ? head_ev.stamp : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q     <= '0;
            prev_valid <= 1'b0;
            wrap_count <= '0;
            overflow   <= 1'b0;
        end else begin
            prev_q     <= count_in;
            prev_valid <= 1'b1;
            if (wrap) wrap_count <= wrap_next;
            if (event_hit && fifo_full && !pop) overflow <= 1'b1;
        end
    end

    event_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (event_hit),
        .push_data (push_ev),
        .pop       (pop),
        .pop_data  (head_ev),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: doc/count_event_monitor.md
COUNT_EVENT_MONITOR -- requirements
Module: count_event_monitor

Interface
REQ-001 Parameter N, default 4: width of the count input; matches the upstream pipelined down counter width.
REQ-002 Parameter DEPTH, default 4: event FIFO depth; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 count_in  input  N  current value from the upstream down counter.
REQ-006 cmp_en  input  1  enables match detection.
REQ-007 cmp_value  input  N  match threshold, sampled every cycle.
REQ-008 evt_valid  output  1  FIFO head holds an event.
REQ-009 evt_ready  input  1  consumer accepts the head event.
REQ-010 evt_type  output  2  head event type: 01 match, 10 wrap, 11 both.
REQ-011 evt_stamp  output  8  wrap_count value recorded with the head event.
REQ-012 wrap_count  output  8  running count of detected wraps, modulo 256.
REQ-013 overflow  output  1  sticky flag: an event was dropped.

Function
REQ-014 Each cycle SHALL register count_in into prev_q; prev_valid SHALL set at the first clock edge after reset release.
REQ-015 Wrap SHALL be detected when prev_valid=1, prev_q=0 and count_in=all-ones.
REQ-016 Match SHALL be detected when prev_valid=1, cmp_en=1, count_in=cmp_value and count_in!=prev_q; repeated identical samples (e.g. the all-ones reset hold) yield no further match.
REQ-017 An event is any cycle with wrap or match; evt_type SHALL be {wrap, match}.
REQ-018 On wrap, wrap_count SHALL increment by 1 at that edge (255 wraps to 0); evt_stamp SHALL be the incremented value.
REQ-019 Events SHALL be pushed into the FIFO at the edge where they are detected; evt_valid SHALL rise in the following cycle when the FIFO was empty (latency 1).
REQ-020 Pop SHALL occur when evt_valid=1 and evt_ready=1; FIFO order is strict FIFO.
REQ-021 Push SHALL be accepted when the FIFO is not full, or when full and a pop occurs in the same cycle.
REQ-022 An event arriving while full without a simultaneous pop SHALL be dropped and SHALL set overflow; wrap_count still increments.
REQ-023 overflow SHALL clear only on reset.
REQ-024 Simultaneous push and pop on an empty FIFO SHALL NOT occur, since evt_valid=0; push-only proceeds.
REQ-025 evt_type and evt_stamp SHALL be 0 whenever evt_valid=0.

Reset
REQ-026 Asserting reset SHALL immediately clear prev_q, prev_valid, wrap_count, overflow, FIFO pointers and occupancy, and drive evt_valid, evt_type and evt_stamp to 0.
REQ-027 Reset asserted mid-operation SHALL discard all queued events; the first post-reset sample SHALL only load prev_q and SHALL NOT produce an event.

Structure
REQ-028 Shared package count_event_pkg SHALL hold the evt_type encodings (EVT_MATCH=01, EVT_WRAP=10, EVT_BOTH=11) and STAMP_W=8.
REQ-029 Storage SHALL be a sub-module event_fifo (width 2+STAMP_W, depth DEPTH) with push, pop, full, empty; detection logic stays in the top level.

Verification
REQ-030 Reset, then count_in=15 for 3 cycles, then 14,13,12..., cmp_en=1, cmp_value=13, evt_ready=1 -> exactly one event, type 01, stamp 0, evt_valid high the cycle after 13 is presented.
REQ-031 count_in 1,0,15,14 with cmp_en=0 -> one event, type 10, stamp 1, wrap_count=1.
REQ-032 cmp_value=15, cmp_en=1, count_in transitions 0->15 -> one event, type 11, stamp incremented.
REQ-033 evt_ready=0, five events -> four stored, overflow=1; then evt_ready=1 -> four events drained in order, overflow remains 1.
REQ-034 FIFO full, event arrives with evt_valid=1 and evt_ready=1 in the same cycle -> new event accepted, overflow stays 0, occupancy stays DEPTH.
REQ-035 Reset pulsed with three queued events and wrap_count=5 -> all outputs 0 immediately; the next 15->15 and 0->15 samples behave per REQ-027 and REQ-015.
